// File: rtl/riscv_pkg.sv
// Shared types and default sizing for the barrel-threaded core's issue sequencer.
package riscv_pkg;

    typedef enum logic [1:0] {
        THR_IDLE   = 2'd0,
        THR_RUN    = 2'd1,
        THR_HALTED = 2'd2
    } thread_state_e;

    localparam logic [0:0] GST_CLEAR = 1'b0;
    localparam logic [0:0] GST_READY = 1'b1;

    localparam int NUM_THREADS_DEF     = 16;
    localparam int NUM_PIPE_STAGES_DEF = 16;
    localparam int REGFILE_SIZE_DEF    = 32;

    localparam int TID_W = $clog2(NUM_THREADS_DEF);
    localparam int CLR_W = $clog2(NUM_THREADS_DEF * REGFILE_SIZE_DEF);

endpackage

// File: rtl/barrel_thread_scheduler_tid_delay_line.sv
// Shift register carrying {valid, tid} from issue to writeback.
module tid_delay_line #(
    parameter int DEPTH = 15,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    output logic [WIDTH-1:0] out_o,
    output logic             any_valid_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = in_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    // Valid is the MSB of each stage; used to decide when writeback has drained.
    always_comb begin
        any_valid_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            any_valid_o = any_valid_o | stage_q[i][WIDTH-1];
        end
    end

    assign out_o = stage_q[DEPTH-1];

endmodule

// File: rtl/barrel_thread_scheduler.sv
// Issue-slot sequencer: round-robin thread rotation gated by run state,
// writeback tag delay line, and post-reset register-file clear sweep.
module barrel_thread_scheduler
    import riscv_pkg::*;
#(
    parameter int NUM_THREADS     = NUM_THREADS_DEF,
    parameter int NUM_PIPE_STAGES = NUM_PIPE_STAGES_DEF,
    parameter int REGFILE_SIZE    = REGFILE_SIZE_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_i,
    input  logic [NUM_THREADS-1:0]           start_mask_i,
    input  logic                             halt_valid_i,
    input  logic [$clog2(NUM_THREADS)-1:0]   halt_tid_i,
    output logic                             issue_valid_o,
    output logic [$clog2(NUM_THREADS)-1:0]   issue_tid_o,
    output logic                             issue_first_o,
    output logic                             wb_valid_o,
    output logic [$clog2(NUM_THREADS)-1:0]   wb_tid_o,
    output logic                             rf_clr_we_o,
    output logic [$clog2(NUM_THREADS)+4:0]   rf_clr_addr_o,
    output logic                             busy_o,
    output logic [NUM_THREADS-1:0]           active_mask_o,
    output logic                             all_halted_o
);

    localparam int TW       = $clog2(NUM_THREADS);
    localparam int CW       = $clog2(NUM_THREADS * REGFILE_SIZE);
    localparam int AW       = TW + 5;
    localparam int WB_DEPTH = NUM_PIPE_STAGES - 1;
    localparam logic [CW-1:0] CLR_LAST = CW'(NUM_THREADS * REGFILE_SIZE - 1);

    if ((NUM_THREADS & (NUM_THREADS - 1)) != 0 || NUM_THREADS < NUM_PIPE_STAGES) begin : g_bad_cfg
        $error("barrel_thread_scheduler: NUM_THREADS must be a power of 2 and >= NUM_PIPE_STAGES");
    end

    logic [0:0]             gst_q, gst_d;
    logic [CW-1:0]          clr_cnt_q, clr_cnt_d;
    logic [TW-1:0]          slot_cnt_q, slot_cnt_d;
    logic [NUM_THREADS-1:0] pending_q, pending_d;
    logic [NUM_THREADS-1:0] first_q, first_d;
    thread_state_e          thr_q [NUM_THREADS];
    thread_state_e          thr_d [NUM_THREADS];

    logic                   issue_valid_q, issue_valid_d;
    logic [TW-1:0]          issue_tid_q, issue_tid_d;
    logic                   issue_first_q, issue_first_d;
    logic                   rf_clr_we_q, rf_clr_we_d;
    logic [AW-1:0]          rf_clr_addr_q, rf_clr_addr_d;
    logic                   busy_q, busy_d;
    logic [NUM_THREADS-1:0] active_q, active_d;
    logic                   all_halted_q, all_halted_d;

    logic [NUM_THREADS-1:0] launch;
    logic                   any_run, any_halt, pipe_busy;
    logic [TW:0]            wb_word;

    always_comb begin
        gst_d         = gst_q;
        clr_cnt_d     = clr_cnt_q;
        slot_cnt_d    = slot_cnt_q;
        pending_d     = pending_q;
        first_d       = first_q;
        thr_d         = thr_q;
        launch        = '0;
        rf_clr_we_d   = (gst_q == GST_CLEAR);
        rf_clr_addr_d = AW'(clr_cnt_q);
        busy_d        = (gst_q == GST_CLEAR);
        issue_valid_d = 1'b0;
        issue_tid_d   = slot_cnt_q;
        issue_first_d = 1'b0;

        if (gst_q == GST_CLEAR) begin
            // Starts seen during the sweep are banked and released together on READY entry.
            pending_d = pending_q | (start_i ? start_mask_i : '0);
            if (clr_cnt_q == CLR_LAST) begin
                gst_d     = GST_READY;
                launch    = pending_d;
                pending_d = '0;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end else begin
            slot_cnt_d    = slot_cnt_q + 1'b1;
            issue_valid_d = (thr_q[slot_cnt_q] == THR_RUN);
            issue_first_d = first_q[slot_cnt_q] & issue_valid_d;
            if (issue_valid_d) begin
                first_d[slot_cnt_q] = 1'b0;
            end
            if (start_i) begin
                launch = start_mask_i;
            end
        end

        for (int t = 0; t < NUM_THREADS; t++) begin
            if (launch[t] && thr_q[t] != THR_RUN) begin
                thr_d[t]   = THR_RUN;
                first_d[t] = 1'b1;
            end
        end

        // Applied after launch so a simultaneous halt on the same thread wins.
        if (halt_valid_i) begin
            thr_d[halt_tid_i]   = THR_HALTED;
            first_d[halt_tid_i] = 1'b0;
        end
    end

    always_comb begin
        any_run  = 1'b0;
        any_halt = 1'b0;
        active_d = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            any_run     = any_run  | (thr_q[t] == THR_RUN);
            any_halt    = any_halt | (thr_q[t] == THR_HALTED);
            active_d[t] = (thr_d[t] == THR_RUN);
        end
        all_halted_d = (gst_q == GST_READY) && !any_run && any_halt &&
                       !issue_valid_q && !pipe_busy;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gst_q         <= GST_CLEAR;
            clr_cnt_q     <= '0;
            slot_cnt_q    <= '0;
            pending_q     <= '0;
            first_q       <= '0;
            for (int t = 0; t < NUM_THREADS; t++) begin
                thr_q[t] <= THR_IDLE;
            end
            issue_valid_q <= 1'b0;
            issue_tid_q   <= '0;
            issue_first_q <= 1'b0;
            rf_clr_we_q   <= 1'b0;
            rf_clr_addr_q <= '0;
            busy_q        <= 1'b1;
            active_q      <= '0;
            all_halted_q  <= 1'b0;
        end else begin
            gst_q         <= gst_d;
            clr_cnt_q     <= clr_cnt_d;
            slot_cnt_q    <= slot_cnt_d;
            pending_q     <= pending_d;
            first_q       <= first_d;
            for (int t = 0; t < NUM_THREADS; t++) begin
                thr_q[t] <= thr_d[t];
            end
            issue_valid_q <= issue_valid_d;
            issue_tid_q   <= issue_tid_d;
            issue_first_q <= issue_first_d;
            rf_clr_we_q   <= rf_clr_we_d;
            rf_clr_addr_q <= rf_clr_addr_d;
            busy_q        <= busy_d;
            active_q      <= active_d;
            all_halted_q  <= all_halted_d;
        end
    end

    tid_delay_line #(
        .DEPTH (WB_DEPTH),
        .WIDTH (TW + 1)
    ) u_wb_delay (
        .clk         (clk),
        .rst         (reset),
        .in_i        ({issue_valid_q, issue_tid_q}),
        .out_o       (wb_word),
        .any_valid_o (pipe_busy)
    );

    assign issue_valid_o = issue_valid_q;
    assign issue_tid_o   = issue_tid_q;
    assign issue_first_o = issue_first_q;
    assign wb_valid_o    = wb_word[TW];
    assign wb_tid_o      = wb_word[TW-1:0];
    assign rf_clr_we_o   = rf_clr_we_q;
    assign rf_clr_addr_o = rf_clr_addr_q;
    assign busy_o        = busy_q;
    assign active_mask_o = active_q;
    assign all_halted_o  = all_halted_q;

endmodule
